// File: rtl/nios_system_onchip_loader_pkg.sv
// Shared types and constants for the on-chip memory byte-stream loader.
// Imported by the packer and the loader top level.
package nios_system_onchip_loader_pkg;

  localparam int ADDR_W_DEFAULT = 14;
  localparam int DEPTH_DEFAULT  = 16384;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BYTEEN_FULL    = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/nios_system_onchip_loader_packer.sv
// Little-endian byte-to-word packer: byte 0 lands in [7:0].
// Flags the byte that completes a word so the FSM can issue the write.
module nios_system_onchip_loader_packer
  import nios_system_onchip_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      word_q;

  assign word       = word_q;
  assign word_ready = accept && (idx_q == LAST_IDX);

  // The lane register is kept across clear so the
  // completed word stays stable through the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (accept) begin
      word_q[{idx_q, 3'b000} +: 8] <= in_data;
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/nios_system_onchip_loader.sv
// Loads a byte stream into on-chip memory via s1, holding the
// CPU's reset_req while loading; keeps a running word checksum.
module nios_system_onchip_loader
  import nios_system_onchip_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_reset_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W+1:0] DEPTH_W =
    (ADDR_W+2)'(DEPTH);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic [31:0]       csum_q;
  logic              err_q;

  logic [ADDR_W+1:0] end_addr;
  logic              over;
  logic              accept;
  logic              last_word;
  logic              word_ready;
  logic [31:0]       word;

  assign end_addr  = {2'b00, base_addr}
                   + {1'b0, num_words};
  assign over      = end_addr > DEPTH_W;
  assign accept    = in_valid && in_ready;
  assign last_word = rem_q == (ADDR_W+1)'(1);

  nios_system_onchip_loader_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q != LOAD),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (over)                 state_d = IDLE;
          else if (num_words == '0) state_d = DONE;
          else                      state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort)           state_d = IDLE;
        else if (word_ready) state_d = WRITE;
      end
      WRITE: begin
        if (abort)          state_d = IDLE;
        else if (last_word) state_d = DONE;
        else                state_d = LOAD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write in flight when abort arrives still counts.
  // ptr holds on the last word so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && start && over;
      unique case (state_q)
        IDLE: begin
          if (start && !over) begin
            ptr_q  <= base_addr;
            rem_q  <= num_words;
            csum_q <= '0;
          end
        end
        WRITE: begin
          csum_q <= csum_q + word;
          rem_q  <= rem_q - 1'b1;
          if (!last_word) ptr_q <= ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    done           = 1'b0;
    unique case (state_q)
      LOAD: in_ready = 1'b1;
      WRITE: begin
        mem_address    = ptr_q;
        mem_byteenable = BYTEEN_FULL;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = word;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy          = state_q != IDLE;
  assign mem_reset_req = busy;
  assign error         = err_q;
  assign checksum      = csum_q;

endmodule
